// File: rtl/shift_add_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiplier control sequencer:
// state encoding, control-strobe bundle and the Moore output decoder.
package shift_add_defs;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_ADD   = 3'd4;
    localparam logic [2:0] S_SHIFT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CLEAR = S_CLEAR,
        ST_LOAD  = S_LOAD,
        ST_CHECK = S_CHECK,
        ST_ADD   = S_ADD,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE,
        ST_ABORT = S_ABORT
    } state_e;

    typedef struct packed {
        logic clr_regs;
        logic ld_ops;
        logic acc_en;
        logic shift_en;
        logic busy;
        logic result_valid;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_IDLE:  c = '0;
            ST_CLEAR: begin c.clr_regs = 1'b1; c.busy = 1'b1; end
            ST_LOAD:  begin c.ld_ops   = 1'b1; c.busy = 1'b1; end
            ST_CHECK: c.busy = 1'b1;
            ST_ADD:   begin c.acc_en   = 1'b1; c.busy = 1'b1; end
            ST_SHIFT: begin c.shift_en = 1'b1; c.busy = 1'b1; end
            ST_DONE:  begin c.result_valid = 1'b1; c.busy = 1'b1; end
            ST_ABORT: begin c.clr_regs = 1'b1; c.busy = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_add_sequencer_rise_detect.sv
// Rising-edge detector for an already-synchronised level input.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    // previous-sample path and edge pulse
    always_comb begin
        din_d = din;
        rise  = din & ~din_q;
    end

    // previous-sample flop, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

endmodule

// File: rtl/shift_add_sequencer.sv
// Control sequencer for the shift-and-add multiplier datapath with start edge
// detection, iteration bound, abort and a result valid/ack handshake.
module shift_add_sequencer
    import shift_add_defs::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ITER_W = 4
) (
    input  logic              clk_100MHz,
    input  logic              reset_butt_n,
    input  logic              start_butt,
    input  logic              abort_butt,
    input  logic              result_ack,
    input  logic              a_zero,
    input  logic              b_zero,
    input  logic              b_lsb,
    output logic              clr_regs,
    output logic              ld_ops,
    output logic              acc_en,
    output logic              shift_en,
    output logic              busy,
    output logic              result_valid,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(WIDTH);

    state_e            state_q;
    state_e            state_d;
    state_e            state_nxt_s;
    logic [ITER_W-1:0] iter_cnt_q;
    logic [ITER_W-1:0] iter_cnt_d;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    logic              start_rise_s;
    logic              abort_hit_s;

    rise_detect u_start_rise (
        .clk   (clk_100MHz),
        .rst_n (reset_butt_n),
        .din   (start_butt),
        .rise  (start_rise_s)
    );

    // next-state and iteration counter; abort overrides every busy state but ABORT
    always_comb begin
        state_nxt_s = state_q;
        iter_cnt_d  = iter_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (abort_butt) begin
                    state_nxt_s = ST_IDLE;
                end else if (start_rise_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_nxt_s = ST_LOAD;
            ST_LOAD: begin
                state_nxt_s = ST_CHECK;
                iter_cnt_d  = '0;
            end
            ST_CHECK: begin
                if (a_zero || b_zero) begin
                    state_nxt_s = ST_DONE;
                end else if (b_lsb) begin
                    state_nxt_s = ST_ADD;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_ADD: state_nxt_s = ST_SHIFT;
            ST_SHIFT: begin
                iter_cnt_d  = (iter_cnt_q < ITER_MAX) ? iter_cnt_q + ITER_W'(1) : iter_cnt_q;
                state_nxt_s = (iter_cnt_q >= ITER_LAST) ? ST_DONE : ST_CHECK;
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_ABORT: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
        abort_hit_s = abort_butt && (state_q != ST_IDLE) && (state_q != ST_ABORT);
        state_d     = abort_hit_s ? ST_ABORT : state_nxt_s;
        ctrl_d      = decode_ctrl(state_d);
    end

    // state, counter and registered Moore outputs
    always_ff @(posedge clk_100MHz) begin
        if (!reset_butt_n) begin
            state_q    <= ST_IDLE;
            iter_cnt_q <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign clr_regs     = ctrl_q.clr_regs;
    assign ld_ops       = ctrl_q.ld_ops;
    assign acc_en       = ctrl_q.acc_en;
    assign shift_en     = ctrl_q.shift_en;
    assign busy         = ctrl_q.busy;
    assign result_valid = ctrl_q.result_valid;
    assign iter_cnt     = iter_cnt_q;

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Scoreboard bench: models the A/B/result datapath around the sequencer and
// checks product, latency, strobe counts and iteration count per operation.
module tb_shift_add_sequencer;

    localparam int WIDTH  = 8;
    localparam int ITER_W = 4;

    logic              clk_100MHz = 1'b0;
    logic              reset_butt_n;
    logic              start_butt;
    logic              abort_butt;
    logic              result_ack;
    logic              a_zero;
    logic              b_zero;
    logic              b_lsb;
    logic              clr_regs;
    logic              ld_ops;
    logic              acc_en;
    logic              shift_en;
    logic              busy;
    logic              result_valid;
    logic [ITER_W-1:0] iter_cnt;

    logic [15:0] reg_a;
    logic [7:0]  reg_b;
    logic [15:0] reg_r;
    logic [7:0]  op_a;
    logic [7:0]  op_b;

    typedef struct {
        int product;
        int lat;
        int accs;
        int shifts;
        int iters;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ops_started = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    shift_add_sequencer #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .clk_100MHz   (clk_100MHz),
        .reset_butt_n (reset_butt_n),
        .start_butt   (start_butt),
        .abort_butt   (abort_butt),
        .result_ack   (result_ack),
        .a_zero       (a_zero),
        .b_zero       (b_zero),
        .b_lsb        (b_lsb),
        .clr_regs     (clr_regs),
        .ld_ops       (ld_ops),
        .acc_en       (acc_en),
        .shift_en     (shift_en),
        .busy         (busy),
        .result_valid (result_valid),
        .iter_cnt     (iter_cnt)
    );

    assign a_zero = (reg_a == 16'd0);
    assign b_zero = (reg_b == 8'd0);
    assign b_lsb  = reg_b[0];

    // datapath model driven by the control strobes
    always @(posedge clk_100MHz) begin
        if (clr_regs) begin
            reg_a <= 16'd0; reg_b <= 8'd0; reg_r <= 16'd0;
        end else if (ld_ops) begin
            reg_a <= {8'd0, op_a}; reg_b <= op_b;
        end else if (acc_en) begin
            reg_r <= reg_r + reg_a;
        end else if (shift_en) begin
            reg_a <= reg_a << 1; reg_b <= reg_b >> 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // product by arithmetic; one iteration per bit up to B's highest set bit
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n;
        int   acc;
        n = 0;
        acc = 0;
        if (a != 8'd0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((b >> i) != 8'd0) begin
                    n = i + 1;
                    if (b[i]) acc++;
                end
            end
        end
        e.product = int'(a) * int'(b);
        e.accs    = acc;
        e.shifts  = n;
        e.iters   = n;
        e.lat     = 2 + 2 * n + acc + ((n < WIDTH) ? 1 : 0);
        return e;
    endfunction

    // monitor: tracks each operation from its CLEAR cycle and scores on result_valid
    int mon_cyc;
    int mon_accs;
    int mon_shifts;
    bit mon_active;
    bit prev_busy;
    bit prev_valid;
    initial begin
        mon_active = 1'b0; prev_busy = 1'b0; prev_valid = 1'b0;
        mon_cyc = 0; mon_accs = 0; mon_shifts = 0;
        forever begin
            @(negedge clk_100MHz);
            if (reset_butt_n !== 1'b1) begin
                mon_active = 1'b0; prev_busy = 1'b0; prev_valid = 1'b0;
            end else begin
                check("strobe_onehot0", ($countones({clr_regs, ld_ops, acc_en, shift_en}) <= 1) ? 1 : 0, 1);
                if (clr_regs && !prev_busy) begin
                    mon_active = 1'b1; mon_cyc = 0; mon_accs = 0; mon_shifts = 0;
                    ops_started++;
                end else if (mon_active) begin
                    mon_cyc++;
                end
                if (mon_active && acc_en)   mon_accs++;
                if (mon_active && shift_en) mon_shifts++;
                if (result_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("product", int'(reg_r), e.product);
                        check("latency", mon_cyc, e.lat);
                        check("acc_count", mon_accs, e.accs);
                        check("shift_count", mon_shifts, e.shifts);
                        check("iter_cnt", int'(iter_cnt), e.iters);
                    end
                    mon_active = 1'b0;
                end
                if (!busy) mon_active = 1'b0;
                prev_busy  = busy;
                prev_valid = result_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!result_valid && t < 200) begin
            tick();
            t++;
        end
        check("valid_timeout", int'(result_valid), 1);
    endtask

    task automatic ack_result(input int delay, input int iters);
        repeat (delay) tick();
        check("valid_held", int'(result_valid), 1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("valid_clear", int'(result_valid), 0);
        check("busy_after_ack", int'(busy), 0);
        check("iter_hold", int'(iter_cnt), iters);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int ack_delay);
        exp_t e;
        e = model(a, b);
        op_a = a;
        op_b = b;
        exp_q.push_back(e);
        start_butt = 1'b1;
        tick();
        start_butt = 1'b0;
        wait_valid();
        ack_result(ack_delay, e.iters);
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({clr_regs, ld_ops, acc_en, shift_en, busy, result_valid, iter_cnt}), 0);
    endtask

    initial begin
        int ops0;
        int t;
        logic [7:0] ra;
        logic [7:0] rb;
        reset_butt_n = 1'b0; start_butt = 1'b0; abort_butt = 1'b0; result_ack = 1'b0;
        op_a = 8'd0; op_b = 8'd0;
        repeat (3) tick();
        check_all_zero("reset_state");
        reset_butt_n = 1'b1;
        tick();

        run_op(8'd13, 8'd11, 2);
        run_op(8'd37, 8'd0, 0);
        run_op(8'd0, 8'd91, 1);
        run_op(8'd255, 8'd255, 3);
        run_op(8'd1, 8'd128, 0);

        // start held high: exactly one operation, then a fresh rise starts another
        ops0 = ops_started;
        op_a = 8'd13; op_b = 8'd11;
        exp_q.push_back(model(8'd13, 8'd11));
        start_butt = 1'b1;
        repeat (50) tick();
        check("held_valid", int'(result_valid), 1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        repeat (5) tick();
        check("held_busy", int'(busy), 0);
        check("held_one_op", ops_started - ops0, 1);
        start_butt = 1'b0;
        tick();
        run_op(8'd9, 8'd6, 1);
        check("second_op", ops_started - ops0, 2);

        // abort during the ADD at cycle 6
        op_a = 8'd13; op_b = 8'd11;
        start_butt = 1'b1;
        tick();
        start_butt = 1'b0;
        check("abort_clear_c0", int'(clr_regs), 1);
        repeat (6) tick();
        check("abort_at_add", int'(acc_en), 1);
        abort_butt = 1'b1;
        tick();
        abort_butt = 1'b0;
        check("abort_clr", int'(clr_regs), 1);
        check("abort_busy", int'(busy), 1);
        tick();
        check("abort_idle", int'(busy), 0);
        repeat (4) tick();
        check("abort_no_valid", int'(result_valid), 0);

        // reset during SHIFT, then reset with abort+start held
        op_a = 8'd255; op_b = 8'd255;
        start_butt = 1'b1;
        tick();
        start_butt = 1'b0;
        t = 0;
        while (!shift_en && t < 20) begin
            tick();
            t++;
        end
        check("reach_shift", int'(shift_en), 1);
        reset_butt_n = 1'b0;
        tick();
        check_all_zero("reset_in_shift");
        abort_butt = 1'b1;
        start_butt = 1'b1;
        tick();
        check_all_zero("reset_abort_start");
        reset_butt_n = 1'b1;
        repeat (3) tick();
        check("abort_blocks_start", int'(busy), 0);
        abort_butt = 1'b0;
        repeat (3) tick();
        check("start_not_queued", int'(busy), 0);
        start_butt = 1'b0;
        tick();

        for (int k = 0; k < 12; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            run_op(ra, rb, $urandom_range(0, 3));
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
